// File: rtl/vproc_fpu_arbiter_if.sv
// ----------------------------------------------------------------------------
// vproc_fpu_arbiter_if
//
// Purpose : bundles the requester-side, FPU-issue-side and FPU-result-side
//           handshake signals of vproc_fpu_arbiter. Signal names keep the
//           arbiter's point of view (_i = into the arbiter, _o = out of it).
//
// Modports:
//   slave  - the arbiter itself (consumes _i, drives _o)
//   master - the surrounding logic: dispatch, FPU wrapper, or a testbench
//
// Signal summary:
//   req_valid_i/req_ready_o/req_data_i/req_lock_i  per-requester issue side
//   unit_in_valid_o/unit_in_ready_i/unit_in_data_o/unit_in_id_o  to FPU
//   unit_flush_o                                   flush forwarded to FPU
//   unit_out_valid_i/unit_out_ready_o/unit_out_data_i/unit_out_id_i  from FPU
//   resp_valid_o/resp_ready_i/resp_data_o          per-requester responses
//   outst_cnt_o, idle_o                            status
// ----------------------------------------------------------------------------
interface vproc_fpu_arbiter_if #(
    parameter int unsigned REQ_W     = 200,
    parameter int unsigned RES_W     = 69,
    parameter int unsigned MAX_OUTST = 4
);
    localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);

    logic [1:0]                   req_valid_i;
    logic [1:0]                   req_ready_o;
    logic [1:0][REQ_W-1:0]        req_data_i;
    logic [1:0]                   req_lock_i;

    logic                         unit_in_valid_o;
    logic                         unit_in_ready_i;
    logic [REQ_W-1:0]             unit_in_data_o;
    logic                         unit_in_id_o;
    logic                         unit_flush_o;

    logic                         unit_out_valid_i;
    logic                         unit_out_ready_o;
    logic [RES_W-1:0]             unit_out_data_i;
    logic                         unit_out_id_i;

    logic [1:0]                   resp_valid_o;
    logic [1:0]                   resp_ready_i;
    logic [1:0][RES_W-1:0]        resp_data_o;

    logic [1:0][CNT_W-1:0]        outst_cnt_o;
    logic                         idle_o;

    modport slave (
        input  req_valid_i, req_data_i, req_lock_i,
        input  unit_in_ready_i,
        input  unit_out_valid_i, unit_out_data_i, unit_out_id_i,
        input  resp_ready_i,
        output req_ready_o,
        output unit_in_valid_o, unit_in_data_o, unit_in_id_o, unit_flush_o,
        output unit_out_ready_o,
        output resp_valid_o, resp_data_o,
        output outst_cnt_o, idle_o
    );

    modport master (
        output req_valid_i, req_data_i, req_lock_i,
        output unit_in_ready_i,
        output unit_out_valid_i, unit_out_data_i, unit_out_id_i,
        output resp_ready_i,
        input  req_ready_o,
        input  unit_in_valid_o, unit_in_data_o, unit_in_id_o, unit_flush_o,
        input  unit_out_ready_o,
        input  resp_valid_o, resp_data_o,
        input  outst_cnt_o, idle_o
    );
endinterface

// File: rtl/vproc_fpu_arbiter.sv
// ----------------------------------------------------------------------------
// vproc_fpu_arbiter
//
// Purpose : shares one pipelined FPU between the vector FPU stage
//           (requester 0) and the scalar-core FP offload port (requester 1).
//           Round-robin issue with a per-requester in-flight credit limit.
//           The requester ID rides in the FPU tag and responses are steered
//           back by it, so out-of-order completion across opgroups is fine.
//
// Ports   : clk_i         clock
//           async_rst_ni  asynchronous active-low reset
//           flush_i       synchronous flush (clears state, forwarded to FPU)
//           bus           vproc_fpu_arbiter_if.slave, all handshakes/status
//
// Options : define VPROC_FPU_ARB_LOCK_EN to let a requester hold the grant
//           across consecutive issues (req_lock_i); otherwise req_lock_i
//           is ignored and no lock state exists.
// ----------------------------------------------------------------------------
module vproc_fpu_arbiter #(
    parameter int unsigned REQ_W     = 200,
    parameter int unsigned RES_W     = 69,
    parameter int unsigned MAX_OUTST = 4
) (
    input  logic                 clk_i,
    input  logic                 async_rst_ni,
    input  logic                 flush_i,
    vproc_fpu_arbiter_if.slave   bus
);
    localparam int unsigned      CNT_W   = $clog2(MAX_OUTST + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTST);

    logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic                  rr_ptr_q, rr_ptr_d;
    logic                  pend_vld_q, pend_vld_d;
    logic                  pend_id_q, pend_id_d;
    logic                  lock_vld_s, lock_id_s;

    logic [1:0]            elig_s;
    logic                  grant_vld_s, grant_id_s;
    logic                  in_valid_s;
    logic                  issue_hs_s, resp_hs_s;

`ifdef VPROC_FPU_ARB_LOCK_EN
    logic lock_vld_q, lock_vld_d;
    logic lock_id_q, lock_id_d;

    assign lock_vld_s = lock_vld_q;
    assign lock_id_s  = lock_id_q;

    // Lock next state: set by a locking issue, released by the owner's next
    // non-locking issue.
    always_comb begin
        lock_vld_d = lock_vld_q;
        lock_id_d  = lock_id_q;
        if (flush_i) begin
            lock_vld_d = 1'b0;
            lock_id_d  = 1'b0;
        end else if (issue_hs_s && bus.req_lock_i[grant_id_s]) begin
            lock_vld_d = 1'b1;
            lock_id_d  = grant_id_s;
        end else if (issue_hs_s && lock_vld_q && (grant_id_s == lock_id_q)) begin
            lock_vld_d = 1'b0;
        end else begin
            lock_vld_d = lock_vld_q;
        end
    end

    // Lock state register.
    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            lock_vld_q <= 1'b0;
            lock_id_q  <= 1'b0;
        end else begin
            lock_vld_q <= lock_vld_d;
            lock_id_q  <= lock_id_d;
        end
    end
`else
    logic unused_lock_s;
    assign unused_lock_s = ^bus.req_lock_i;
    assign lock_vld_s    = 1'b0;
    assign lock_id_s     = 1'b0;
`endif

    // Eligibility: valid request and a free credit.
    always_comb begin
        elig_s = 2'b00;
        for (int r = 0; r < 2; r++) begin
            elig_s[r] = bus.req_valid_i[r] && (cnt_q[r] < MAX_CNT);
        end
    end

    // Grant selection: a stalled grant is held, then a lock, then round robin.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_id_s  = rr_ptr_q;
        if (pend_vld_q) begin
            grant_vld_s = 1'b1;
            grant_id_s  = pend_id_q;
        end else if (lock_vld_s) begin
            grant_vld_s = 1'b1;
            grant_id_s  = lock_id_s;
        end else if (elig_s[rr_ptr_q]) begin
            grant_vld_s = 1'b1;
            grant_id_s  = rr_ptr_q;
        end else if (elig_s[~rr_ptr_q]) begin
            grant_vld_s = 1'b1;
            grant_id_s  = ~rr_ptr_q;
        end else begin
            grant_vld_s = 1'b0;
        end
    end

    assign in_valid_s = grant_vld_s && elig_s[grant_id_s] && !flush_i;
    assign issue_hs_s = in_valid_s && bus.unit_in_ready_i;
    // A flush drains the result port: it is accepted but not routed or counted.
    assign resp_hs_s  = bus.unit_out_valid_i && bus.unit_out_ready_o && !flush_i;

    // Issue and response datapath outputs.
    always_comb begin
        bus.unit_in_valid_o = in_valid_s;
        bus.unit_in_data_o  = bus.req_data_i[grant_id_s];
        bus.unit_in_id_o    = grant_id_s;
        bus.req_ready_o     = 2'b00;
        bus.resp_valid_o    = 2'b00;
        if (issue_hs_s) begin
            bus.req_ready_o[grant_id_s] = 1'b1;
        end else begin
            bus.req_ready_o = 2'b00;
        end
        if (!flush_i) begin
            bus.resp_valid_o[bus.unit_out_id_i] = bus.unit_out_valid_i;
            bus.unit_out_ready_o = bus.resp_ready_i[bus.unit_out_id_i];
        end else begin
            bus.unit_out_ready_o = 1'b1;
        end
        bus.resp_data_o[0] = bus.unit_out_data_i;
        bus.resp_data_o[1] = bus.unit_out_data_i;
    end

    assign bus.unit_flush_o = flush_i;
    assign bus.outst_cnt_o  = cnt_q;
    assign bus.idle_o       = (cnt_q[0] == '0) && (cnt_q[1] == '0) && !pend_vld_q;

    // Next state: credits, round-robin pointer and stalled-grant tracking.
    always_comb begin
        cnt_d      = cnt_q;
        rr_ptr_d   = rr_ptr_q;
        pend_vld_d = pend_vld_q;
        pend_id_d  = pend_id_q;
        for (int r = 0; r < 2; r++) begin
            logic inc_s, dec_s;
            inc_s = issue_hs_s && (grant_id_s == 1'(r));
            dec_s = resp_hs_s && (bus.unit_out_id_i == 1'(r));
            if (inc_s && !dec_s) begin
                cnt_d[r] = cnt_q[r] + CNT_W'(1);
            end else if (dec_s && !inc_s && (cnt_q[r] != '0)) begin
                // A response with no credit outstanding is dropped (saturate).
                cnt_d[r] = cnt_q[r] - CNT_W'(1);
            end else begin
                cnt_d[r] = cnt_q[r];
            end
        end
        if (issue_hs_s) begin
            rr_ptr_d   = ~grant_id_s;
            pend_vld_d = 1'b0;
        end else if (in_valid_s) begin
            pend_vld_d = 1'b1;
            pend_id_d  = grant_id_s;
        end else begin
            pend_vld_d = pend_vld_q;
        end
        if (flush_i) begin
            cnt_d      = '0;
            rr_ptr_d   = 1'b0;
            pend_vld_d = 1'b0;
            pend_id_d  = 1'b0;
        end else begin
            pend_id_d  = pend_id_d;
        end
    end

    // State registers.
    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            cnt_q      <= '0;
            rr_ptr_q   <= 1'b0;
            pend_vld_q <= 1'b0;
            pend_id_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            pend_vld_q <= pend_vld_d;
            pend_id_q  <= pend_id_d;
        end
    end

    vproc_fpu_arbiter_chk #(.CNT_W(CNT_W)) u_chk (
        .clk_i       (clk_i),
        .rst_ni      (async_rst_ni),
        .flush_i     (flush_i),
        .resp_hs_i   (resp_hs_s),
        .resp_id_i   (bus.unit_out_id_i),
        .cnt_i       (cnt_q),
        .pend_vld_i  (pend_vld_q),
        .pend_id_i   (pend_id_q),
        .req_valid_i (bus.req_valid_i)
    );
endmodule

// ----------------------------------------------------------------------------
// vproc_fpu_arbiter_chk
//
// Purpose : protocol properties of the arbiter's environment.
// Ports   : handshake/state observation inputs only, no outputs.
// ----------------------------------------------------------------------------
module vproc_fpu_arbiter_chk #(
    parameter int unsigned CNT_W = 3
) (
    input logic                  clk_i,
    input logic                  rst_ni,
    input logic                  flush_i,
    input logic                  resp_hs_i,
    input logic                  resp_id_i,
    input logic [1:0][CNT_W-1:0] cnt_i,
    input logic                  pend_vld_i,
    input logic                  pend_id_i,
    input logic [1:0]            req_valid_i
);
    // A result must belong to an operation that was actually issued.
    property p_no_underflow;
        @(posedge clk_i) disable iff (!rst_ni || flush_i)
            resp_hs_i |-> (cnt_i[resp_id_i] != '0);
    endproperty
    a_no_underflow: assert property (p_no_underflow);

    // A stalled requester must keep its request up until it is taken.
    property p_req_stable;
        @(posedge clk_i) disable iff (!rst_ni || flush_i)
            pend_vld_i |-> req_valid_i[pend_id_i];
    endproperty
    a_req_stable: assert property (p_req_stable);
endmodule

// File: tb/tb_vproc_fpu_arbiter.sv
module tb_vproc_fpu_arbiter;
    localparam int unsigned REQ_W     = 200;
    localparam int unsigned RES_W     = 69;
    localparam int unsigned MAX_OUTST = 4;

    logic clk;
    logic rst_n;
    logic flush;

    vproc_fpu_arbiter_if #(.REQ_W(REQ_W), .RES_W(RES_W), .MAX_OUTST(MAX_OUTST)) bus ();

    vproc_fpu_arbiter #(.REQ_W(REQ_W), .RES_W(RES_W), .MAX_OUTST(MAX_OUTST)) dut (
        .clk_i        (clk),
        .async_rst_ni (rst_n),
        .flush_i      (flush),
        .bus          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One table row = one clock cycle of stimulus plus expected outputs.
    typedef struct {
        logic [1:0] v;
        logic       ir;
        logic       ov;
        logic       oid;
        logic [1:0] rr;
        logic       fl;
        logic [1:0] lk;
        logic       e_iv;
        logic       e_id;
        int         e_c0;
        int         e_c1;
        logic       e_idle;
    } vec_t;

    typedef struct {
        logic             id;
        logic [REQ_W-1:0] data;
    } sb_t;

    vec_t tbl[$];
    sb_t  sb[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   seq[2];

    task automatic add(input logic [1:0] v, input logic ir, input logic ov, input logic oid,
                       input logic [1:0] rr, input logic fl, input logic [1:0] lk,
                       input logic e_iv, input logic e_id, input int e_c0, input int e_c1,
                       input logic e_idle);
        vec_t t;
        t.v = v; t.ir = ir; t.ov = ov; t.oid = oid; t.rr = rr; t.fl = fl; t.lk = lk;
        t.e_iv = e_iv; t.e_id = e_id; t.e_c0 = e_c0; t.e_c1 = e_c1; t.e_idle = e_idle;
        tbl.push_back(t);
    endtask

    task automatic chk(input string name, input int row, input logic [255:0] act,
                       input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
        end
    endtask

    function automatic logic [REQ_W-1:0] pay(input int r, input int s);
        logic [REQ_W-1:0] p;
        p            = '0;
        p[31:0]      = 32'h5A5A_0000 ^ 32'(s);
        p[107:100]   = 8'(s * 3 + r);
        p[REQ_W-1]   = r[0];
        return p;
    endfunction

    initial begin
        logic [1:0]       e_rdy;
        logic [1:0]       e_rv;
        logic             e_ordy;
        logic [RES_W-1:0] odata;
        sb_t              s;

        // Test 1: both valid, immediate responses -> strict alternation.
        add(2'b11, 1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 2'b00, 1'b1, 1'b0, 0, 0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            add(2'b11, 1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 2'b00, 1'b1, 1'b1, 1, 0, 1'b0);
            add(2'b11, 1'b1, 1'b1, 1'b1, 2'b11, 1'b0, 2'b00, 1'b1, 1'b0, 0, 1, 1'b0);
        end
        add(2'b11, 1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 2'b00, 1'b1, 1'b1, 1, 0, 1'b0);
        add(2'b00, 1'b1, 1'b1, 1'b1, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 0, 1, 1'b0);
        // Test 2: requester 0 alone hits the credit limit.
        for (int k = 0; k < 4; k++)
            add(2'b01, 1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 2'b00, 1'b1, 1'b0, k, 0, k == 0);
        add(2'b01, 1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 4, 0, 1'b0);
        add(2'b11, 1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 2'b00, 1'b1, 1'b1, 4, 0, 1'b0);
        add(2'b01, 1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 4, 1, 1'b0);
        add(2'b01, 1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 2'b00, 1'b1, 1'b0, 3, 1, 1'b0);
        add(2'b01, 1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 4, 1, 1'b0);
        for (int k = 0; k < 4; k++)
            add(2'b00, 1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 4 - k, 1, 1'b0);
        add(2'b00, 1'b1, 1'b1, 1'b1, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 0, 1, 1'b0);
        // Test 3: FPU stalls 3 cycles; grant and data held (rr_ptr is 1 here).
        add(2'b01, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 2'b00, 1'b1, 1'b0, 0, 0, 1'b1);
        add(2'b11, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 2'b00, 1'b1, 1'b0, 0, 0, 1'b0);
        add(2'b11, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 2'b00, 1'b1, 1'b0, 0, 0, 1'b0);
        add(2'b11, 1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 2'b00, 1'b1, 1'b0, 0, 0, 1'b0);
        add(2'b11, 1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 2'b00, 1'b1, 1'b1, 1, 0, 1'b0);
        // Test 4: results id 1 then 0, requester 1 back-pressures 2 cycles.
        add(2'b00, 1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 2'b00, 1'b0, 1'b0, 1, 1, 1'b0);
        add(2'b00, 1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 2'b00, 1'b0, 1'b0, 1, 1, 1'b0);
        add(2'b00, 1'b1, 1'b1, 1'b1, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 1, 1, 1'b0);
        add(2'b00, 1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 1, 0, 1'b0);
        // Test 5: build cnt0=3, cnt1=2 plus a stalled grant, then flush.
        add(2'b11, 1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 2'b00, 1'b1, 1'b0, 0, 0, 1'b1);
        add(2'b11, 1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 2'b00, 1'b1, 1'b1, 1, 0, 1'b0);
        add(2'b11, 1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 2'b00, 1'b1, 1'b0, 1, 1, 1'b0);
        add(2'b11, 1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 2'b00, 1'b1, 1'b1, 2, 1, 1'b0);
        add(2'b11, 1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 2'b00, 1'b1, 1'b0, 2, 2, 1'b0);
        add(2'b11, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 2'b00, 1'b1, 1'b1, 3, 2, 1'b0);
        add(2'b11, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 3, 2, 1'b0);
        add(2'b00, 1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 0, 0, 1'b1);
        add(2'b11, 1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 2'b00, 1'b1, 1'b0, 0, 0, 1'b1);
        add(2'b00, 1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 1, 0, 1'b0);
        // Test 6: lock chain 1,1,0 from requester 0 (rr_ptr is 1 on entry).
        add(2'b10, 1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 2'b00, 1'b1, 1'b1, 0, 0, 1'b1);
        add(2'b11, 1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 2'b01, 1'b1, 1'b0, 0, 1, 1'b0);
`ifdef VPROC_FPU_ARB_LOCK_EN
        add(2'b11, 1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 2'b01, 1'b1, 1'b0, 1, 1, 1'b0);
        add(2'b11, 1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 2'b00, 1'b1, 1'b0, 2, 1, 1'b0);
        add(2'b11, 1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 2'b00, 1'b1, 1'b1, 3, 1, 1'b0);
        add(2'b00, 1'b1, 1'b0, 1'b0, 2'b11, 1'b1, 2'b00, 1'b0, 1'b0, 3, 2, 1'b0);
`else
        add(2'b11, 1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 2'b01, 1'b1, 1'b1, 1, 1, 1'b0);
        add(2'b11, 1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 2'b00, 1'b1, 1'b0, 1, 2, 1'b0);
        add(2'b11, 1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 2'b00, 1'b1, 1'b1, 2, 2, 1'b0);
        add(2'b00, 1'b1, 1'b0, 1'b0, 2'b11, 1'b1, 2'b00, 1'b0, 1'b0, 2, 3, 1'b0);
`endif
        add(2'b00, 1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 0, 0, 1'b1);

        // Reset state with idle inputs.
        seq[0] = 0;
        seq[1] = 0;
        rst_n = 1'b0;
        flush = 1'b0;
        bus.req_valid_i      = 2'b00;
        bus.req_data_i       = '0;
        bus.req_lock_i       = 2'b00;
        bus.unit_in_ready_i  = 1'b0;
        bus.unit_out_valid_i = 1'b0;
        bus.unit_out_data_i  = '0;
        bus.unit_out_id_i    = 1'b0;
        bus.resp_ready_i     = 2'b00;
        #3;
        chk("rst_in_valid",  -1, 256'(bus.unit_in_valid_o), 256'(1'b0));
        chk("rst_req_ready", -1, 256'(bus.req_ready_o),     256'(2'b00));
        chk("rst_resp_valid",-1, 256'(bus.resp_valid_o),    256'(2'b00));
        chk("rst_idle",      -1, 256'(bus.idle_o),          256'(1'b1));
        chk("rst_cnt",       -1, 256'(bus.outst_cnt_o),     256'(0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            odata = RES_W'({$urandom(), $urandom(), $urandom()});
            bus.req_valid_i      = tbl[i].v;
            bus.req_data_i[0]    = pay(0, seq[0]);
            bus.req_data_i[1]    = pay(1, seq[1]);
            bus.req_lock_i       = tbl[i].lk;
            bus.unit_in_ready_i  = tbl[i].ir;
            bus.unit_out_valid_i = tbl[i].ov;
            bus.unit_out_id_i    = tbl[i].oid;
            bus.unit_out_data_i  = odata;
            bus.resp_ready_i     = tbl[i].rr;
            flush                = tbl[i].fl;
            #1;
            e_rdy  = (tbl[i].e_iv && tbl[i].ir) ? (tbl[i].e_id ? 2'b10 : 2'b01) : 2'b00;
            e_rv   = (tbl[i].fl || !tbl[i].ov) ? 2'b00 : (tbl[i].oid ? 2'b10 : 2'b01);
            e_ordy = tbl[i].fl ? 1'b1 : tbl[i].rr[tbl[i].oid];
            chk("in_valid",   i, 256'(bus.unit_in_valid_o),  256'(tbl[i].e_iv));
            if (tbl[i].e_iv) begin
                chk("in_id",   i, 256'(bus.unit_in_id_o),    256'(tbl[i].e_id));
                chk("in_data", i, 256'(bus.unit_in_data_o),  256'(pay(int'(tbl[i].e_id), seq[tbl[i].e_id])));
            end
            chk("req_ready",  i, 256'(bus.req_ready_o),      256'(e_rdy));
            chk("resp_valid", i, 256'(bus.resp_valid_o),     256'(e_rv));
            chk("out_ready",  i, 256'(bus.unit_out_ready_o), 256'(e_ordy));
            chk("resp_data0", i, 256'(bus.resp_data_o[0]),   256'(odata));
            chk("resp_data1", i, 256'(bus.resp_data_o[1]),   256'(odata));
            chk("unit_flush", i, 256'(bus.unit_flush_o),     256'(tbl[i].fl));
            chk("cnt0",       i, 256'(bus.outst_cnt_o[0]),   256'(tbl[i].e_c0));
            chk("cnt1",       i, 256'(bus.outst_cnt_o[1]),   256'(tbl[i].e_c1));
            chk("idle",       i, 256'(bus.idle_o),           256'(tbl[i].e_idle));
            // Scoreboard: expected issue pushed now, popped at the DUT handshake.
            if (tbl[i].e_iv && tbl[i].ir) begin
                s.id   = tbl[i].e_id;
                s.data = pay(int'(tbl[i].e_id), seq[tbl[i].e_id]);
                sb.push_back(s);
                seq[tbl[i].e_id] = seq[tbl[i].e_id] + 1;
            end
            if (bus.unit_in_valid_o && bus.unit_in_ready_i) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL sb_unexpected row %0d: got issue id %0d expected none", i, bus.unit_in_id_o);
                end else begin
                    s = sb.pop_front();
                    chk("sb_id",   i, 256'(bus.unit_in_id_o),   256'(s.id));
                    chk("sb_data", i, 256'(bus.unit_in_data_o), 256'(s.data));
                end
            end
        end
        chk("sb_left", -2, 256'(sb.size()), 256'(0));

        // Asynchronous reset in the middle of operation.
        @(negedge clk);
        bus.req_valid_i     = 2'b01;
        bus.unit_in_ready_i = 1'b1;
        flush               = 1'b0;
        @(posedge clk);
        #1;
        chk("pre_rst_cnt0", -3, 256'(bus.outst_cnt_o[0]), 256'(1));
        bus.req_valid_i = 2'b00;
        rst_n = 1'b0;
        #1;
        chk("async_rst_cnt0", -3, 256'(bus.outst_cnt_o[0]), 256'(0));
        chk("async_rst_idle", -3, 256'(bus.idle_o),         256'(1'b1));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
